uart_byte_assembler: RTL
========================

Name: uart_byte_assembler

Overview:
Downstream consumer of the UART bit sampler. It collects the sampler's per-bit pulses (LSB first) into a byte and validates the frame on the stop-bit pulse. Good bytes are pushed into a small first-word-fall-through FIFO with a valid/ready output. Overrun and framing-error status are reported to the host-side logic.

Parameters:
DATA_BITS, 8, bits per frame; must match the sampler's data-bit count.
FIFO_DEPTH, 4, byte FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  asynchronous, active-high reset
align  input  1  sampler pulse: start edge detected
bit_valid  input  1  sampler pulse: bit_data holds a sampled data bit
bit_data  input  1  sampled data bit, qualified by bit_valid
frame_done  input  1  sampler pulse: stop bit sampled
framing_error  input  1  sampler status, registered in the same cycle as frame_done, or a lone pulse on a start glitch
clr_flags  input  1  synchronous clear of overrun and err_count
m_data  output  DATA_BITS  FIFO head byte
m_valid  output  1  FIFO not empty
m_ready  input  1  consumer accepts m_data when m_valid && m_ready
fill_count  output  $clog2(FIFO_DEPTH)+1  bytes held
overrun  output  1  sticky: good byte dropped because FIFO full
err_count  output  8  saturating count of rejected frames

Behaviour:
- Reset (rst high, asynchronous): state IDLE; shift register, bit counter, FIFO pointers cleared.
  - Outputs at reset: m_data=0, m_valid=0, fill_count=0, overrun=0, err_count=0.
- FSM states: IDLE, COLLECT, WAIT_STOP.
- IDLE: align -> clear shift register and bit counter, go to COLLECT. Other inputs are ignored.
- COLLECT:
  - bit_valid -> shift right, with bit_data entering the MSB (LSB-first line order); bit counter +1.
  - When the counter reaches DATA_BITS-1 with bit_valid, go to WAIT_STOP.
  - framing_error without frame_done (start-glitch pulse) -> back to IDLE; byte discarded; not counted.
  - frame_done before the byte is complete (short frame) -> discard, err_count+1, back to IDLE.
- WAIT_STOP:
  - bit_valid is ignored.
  - frame_done with framing_error=0 -> push the byte, back to IDLE.
  - frame_done with framing_error=1 -> discard, err_count+1, back to IDLE.
- align in COLLECT or WAIT_STOP -> resynchronise: clear and restart COLLECT; the partial byte is dropped silently.
- Same-cycle precedence: align over bit_valid; frame_done over align.
- Push latency: frame_done at cycle N -> byte written at the N edge; m_valid=1 and m_data valid from cycle N+1 if the FIFO was empty.
- FIFO: FWFT register array with wrapping read/write pointers.
  - Pop: m_valid && m_ready.
  - m_data is the head entry and is held stable while m_valid && !m_ready.
  - m_data is don't-care when empty; the bench checks it only with m_valid.
- FIFO full:
  - Push without pop -> byte dropped, overrun set to 1 (sticky).
  - Push and pop in the same cycle -> both performed, fill_count unchanged, no overrun.
- FIFO empty: m_ready is ignored; a pop never underflows.
- Simultaneous push and pop when empty: push only; m_valid rises the next cycle.
- fill_count: registered, +1 on push only, -1 on pop only.
- err_count: saturates at 255, no wrap.
- clr_flags: clears overrun and err_count next edge. A same-cycle overrun or error event wins, so the flag or count ends at 1.
- Pointer wrap: FIFO_DEPTH pushes and pops return the pointers to their start; ordering is preserved across the wrap.

Optional Feature:
UART_ASM_STATS_EN
- Defined: err_count is implemented as described above.
- Undefined: err_count is tied to 0, no counter logic is generated, and clr_flags affects only overrun.
- All other behaviour is identical in both builds.

Test Plan:
- Byte 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), good stop, m_ready=1 -> m_valid one cycle after frame_done with m_data=0xA5; fill_count 1 then 0.
- Five good bytes 0x01..0x05, m_ready=0, FIFO_DEPTH=4 -> fill_count=4, overrun=1, then popping yields 0x01..0x04 in order.
- Byte 0x3C with framing_error=1 at frame_done -> no push, err_count=1, m_valid stays 0.
- Start glitch (align then a lone framing_error pulse), followed by a good 0x7E -> only 0x7E is delivered, err_count=0.
- FIFO full, frame_done(good 0x99) with pop in the same cycle -> fill_count stays 4, overrun=0, 0x99 is last out.
- Assert rst after 4 bits of a frame, then send a full 0x55 -> all outputs 0 during reset, then 0x55 delivered cleanly; 256 bad frames -> err_count=255, clr_flags -> 0.

Source files
------------

// File: rtl/uart_byte_assembler.sv
// Collects UART sampler bit pulses (LSB first) into bytes, validates the stop bit and
// buffers good bytes in an FWFT FIFO. Define UART_ASM_STATS_EN to build the err_count counter.
module uart_byte_assembler #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            align,
  input  logic                            bit_valid,
  input  logic                            bit_data,
  input  logic                            frame_done,
  input  logic                            framing_error,
  input  logic                            clr_flags,
  output logic [DATA_BITS-1:0]            m_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fill_count,
  output logic                            overrun,
  output logic [7:0]                      err_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, WAIT_STOP} state_t;

  state_t               state, state_next;
  logic [DATA_BITS-1:0] shift_q, shift_next;
  logic [CW-1:0]        bit_cnt, bit_cnt_next;
  logic                 push;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 full, pop, do_write, drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shift_q <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      shift_q <= shift_next;
      bit_cnt <= bit_cnt_next;
    end
  end

  // Priority inside a frame: frame_done, then align (resync), then glitch, then data bit.
  always_comb begin
    state_next   = state;
    shift_next   = shift_q;
    bit_cnt_next = bit_cnt;
    push         = 1'b0;
    unique case (state)
      IDLE: begin
        if (align) begin
          shift_next   = '0;
          bit_cnt_next = '0;
          state_next   = COLLECT;
        end
      end
      COLLECT: begin
        if (frame_done) begin
          state_next = IDLE;
        end else if (align) begin
          shift_next   = '0;
          bit_cnt_next = '0;
        end else if (framing_error) begin
          state_next = IDLE;
        end else if (bit_valid) begin
          shift_next   = {bit_data, shift_q[DATA_BITS-1:1]};
          bit_cnt_next = bit_cnt + 1'b1;
          if (bit_cnt == CW'(DATA_BITS - 1)) state_next = WAIT_STOP;
        end
      end
      WAIT_STOP: begin
        if (frame_done) begin
          push       = !framing_error;
          state_next = IDLE;
        end else if (align) begin
          shift_next   = '0;
          bit_cnt_next = '0;
          state_next   = COLLECT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign m_valid  = (fill_count != '0);
  assign full     = (fill_count == FW'(FIFO_DEPTH));
  assign pop      = m_valid && m_ready;
  assign do_write = push && (!full || pop);
  assign drop     = push && full && !pop;
  assign m_data   = mem[rd_ptr];

  // A push into a full FIFO succeeds only when the head is leaving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_write) begin
        mem[wr_ptr] <= shift_q;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_write && !pop)      fill_count <= fill_count + 1'b1;
      else if (pop && !do_write) fill_count <= fill_count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            overrun <= 1'b0;
    else if (drop)      overrun <= 1'b1;
    else if (clr_flags) overrun <= 1'b0;
  end

`ifdef UART_ASM_STATS_EN
  logic err_evt;

  // Short frames and bad stop bits are counted; start glitches are not.
  assign err_evt = frame_done &&
                   ((state == COLLECT) || ((state == WAIT_STOP) && framing_error));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 err_count <= '0;
    else if (clr_flags)                      err_count <= err_evt ? 8'd1 : 8'd0;
    else if (err_evt && err_count != 8'hFF)  err_count <= err_count + 8'd1;
  end
`else
  assign err_count = '0;
`endif

endmodule
